qsystop_mem_copy_master: RTL and testbench

Avalon-MM master that copies a block of 32-bit words from one region of the 8192-word single-port on-chip memory to another. It drives the memory's slave port (address, chipselect, write, byteenable, writedata, clken) and consumes its fixed-latency readdata. A simple start/busy/done control interface lets a custom instruction or CSR wrapper launch block moves without CPU load/store loops.

---
 rtl/qsystop_mem_copy_master_if.sv | 24 ++
 rtl/qsystop_mem_copy_master.sv | 119 +++++++++++
 tb/tb_qsystop_mem_copy_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qsystop_mem_copy_master_if.sv
// Avalon-MM bus between the block-copy master and the single-port on-chip memory.
// The master drives address/control/data; the memory returns fixed-latency readdata.
interface qsystop_mem_copy_master_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   m_address;
  logic                m_chipselect;
  logic                m_write;
  logic [DATA_W/8-1:0] m_byteenable;
  logic [DATA_W-1:0]   m_writedata;
  logic                m_clken;
  logic [DATA_W-1:0]   m_readdata;

  modport master (
    output m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_write, m_byteenable, m_writedata, m_clken,
    output m_readdata
  );
endinterface

// File: rtl/qsystop_mem_copy_master.sv
// Avalon-MM block-copy master: reads each word from src+i and writes it to dst+i,
// strictly ascending, with a start/busy/done handshake. All outputs are registered.
module qsystop_mem_copy_master #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  qsystop_mem_copy_master_if.master bus
);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_LAT, ST_WR, ST_DONE} state_t;

  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam logic [2:0]      LAT_LAST = 3'(READ_LATENCY - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, addr_nxt;
  logic [ADDR_W:0]   len_q, idx, idx_inc;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] wdata_nxt;

  assign idx_inc          = idx + ONE;
  assign bus.m_byteenable = '1;
  assign bus.m_clken      = 1'b1;

  // Next state plus the next address/data; the registers below load them on the
  // same edge the state changes, so every bus output is glitch-free and registered.
  always_comb begin
    // NOTE: every signal gets its default first so no path through the case leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt = state;
    addr_nxt  = bus.m_address;
    wdata_nxt = bus.m_writedata;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RD;
            addr_nxt  = src_addr;
          end
        end
      end
      ST_RD:   state_nxt = ST_LAT;
      ST_LAT: begin
        if (lat_cnt == LAT_LAST) begin
          state_nxt = ST_WR;
          addr_nxt  = dst_q + idx[ADDR_W-1:0];
          wdata_nxt = bus.m_readdata;
        end
      end
      ST_WR: begin
        if (idx_inc == len_q) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_RD;
          addr_nxt  = src_q + idx_inc[ADDR_W-1:0];
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy             <= 1'b0;
      done             <= 1'b0;
      words_done       <= '0;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_address    <= '0;
      bus.m_writedata  <= '0;
      src_q            <= '0;
      dst_q            <= '0;
      len_q            <= '0;
      idx              <= '0;
      lat_cnt          <= '0;
    end else begin
      busy             <= state_nxt inside {ST_RD, ST_LAT, ST_WR};
      done             <= (state_nxt == ST_DONE);
      bus.m_chipselect <= state_nxt inside {ST_RD, ST_WR};
      bus.m_write      <= (state_nxt == ST_WR);
      bus.m_address    <= addr_nxt;
      bus.m_writedata  <= wdata_nxt;
      lat_cnt          <= (state == ST_LAT) ? lat_cnt + 3'd1 : 3'd0;
      if (state == ST_IDLE && start) begin
        src_q      <= src_addr;
        dst_q      <= dst_addr;
        len_q      <= length;
        idx        <= '0;
        words_done <= '0;
      end
      // The write issued in this cycle counts as done once the edge commits it.
      if (state == ST_WR) begin
        idx        <= idx_inc;
        words_done <= words_done + ONE;
      end
    end
  end

endmodule

// File: tb/tb_qsystop_mem_copy_master.sv
// Bench for qsystop_mem_copy_master: two DUTs (read latency 1 and 3), each with its
// own Avalon memory model, checked against an array-based reference copy.
module tb_qsystop_mem_copy_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  reset_n_v, start_v, busy_v, done_v, init_v, poke_v, cs_v, wr_v, clken_v;
  logic [12:0] src_v [2];
  logic [12:0] dst_v [2];
  logic [12:0] addr_v [2];
  logic [13:0] len_v [2];
  logic [13:0] wd_v [2];
  logic [31:0] wdata_v [2];
  logic [31:0] seed_v [2];
  logic [3:0]  be_v [2];
  logic [12:0] poke_addr;
  logic [31:0] poke_data;

  logic [31:0] ref_mem [2][8192];
  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] pattern(logic [31:0] seed, logic [12:0] a);
    return ({19'd0, a} * 32'h9E37_79B1) ^ seed;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = (k == 0) ? 1 : 3;

    qsystop_mem_copy_master_if #(.ADDR_W(13), .DATA_W(32)) bus ();

    qsystop_mem_copy_master #(.ADDR_W(13), .DATA_W(32), .READ_LATENCY(L)) dut (
      .clk        (clk),
      .reset_n    (reset_n_v[k]),
      .start      (start_v[k]),
      .src_addr   (src_v[k]),
      .dst_addr   (dst_v[k]),
      .length     (len_v[k]),
      .busy       (busy_v[k]),
      .done       (done_v[k]),
      .words_done (wd_v[k]),
      .bus        (bus.master)
    );

    logic [31:0]  mem [8192];
    logic [31:0]  pipe_d [L];
    logic [L-1:0] pipe_v;

    always @(posedge clk) begin
      if (init_v[k]) begin
        for (int a = 0; a < 8192; a++) mem[a] <= pattern(seed_v[k], 13'(a));
      end else if (poke_v[k]) begin
        mem[poke_addr] <= poke_data;
      end else if (bus.m_clken && bus.m_chipselect && bus.m_write) begin
        mem[bus.m_address] <= bus.m_writedata;
      end
      pipe_v[0] <= reset_n_v[k] && bus.m_chipselect && !bus.m_write;
      pipe_d[0] <= mem[bus.m_address];
      for (int s = 1; s < L; s++) begin
        pipe_v[s] <= pipe_v[s-1];
        pipe_d[s] <= pipe_d[s-1];
      end
    end

    // Readdata is only meaningful exactly L cycles after a read; poison it otherwise.
    assign bus.m_readdata = pipe_v[L-1] ? pipe_d[L-1] : 32'hBAD0_BAD0;
    assign cs_v[k]        = bus.m_chipselect;
    assign wr_v[k]        = bus.m_write;
    assign clken_v[k]     = bus.m_clken;
    assign addr_v[k]      = bus.m_address;
    assign wdata_v[k]     = bus.m_writedata;
    assign be_v[k]        = bus.m_byteenable;
  end

  function automatic logic [31:0] mem_rd(int k, logic [12:0] a);
    return (k == 0) ? g[0].mem[a] : g[1].mem[a];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(int k, string tag);
    check($sformatf("%s k%0d busy", tag, k), busy_v[k], 0);
    check($sformatf("%s k%0d done", tag, k), done_v[k], 0);
    check($sformatf("%s k%0d words_done", tag, k), wd_v[k], 0);
    check($sformatf("%s k%0d chipselect", tag, k), cs_v[k], 0);
    check($sformatf("%s k%0d write", tag, k), wr_v[k], 0);
    check($sformatf("%s k%0d address", tag, k), addr_v[k], 0);
    check($sformatf("%s k%0d writedata", tag, k), wdata_v[k], 0);
    check($sformatf("%s k%0d byteenable", tag, k), be_v[k], 4'hF);
    check($sformatf("%s k%0d clken", tag, k), clken_v[k], 1);
  endtask

  task automatic init_mem(int k, logic [31:0] seed);
    seed_v[k] = seed;
    init_v[k] = 1'b1;
    @(negedge clk);
    init_v[k] = 1'b0;
    for (int a = 0; a < 8192; a++) ref_mem[k][a] = pattern(seed, 13'(a));
  endtask

  task automatic poke(int k, int a, logic [31:0] d);
    poke_addr = 13'(a);
    poke_data = d;
    poke_v[k] = 1'b1;
    @(negedge clk);
    poke_v[k] = 1'b0;
    ref_mem[k][13'(a)] = d;
  endtask

  // Reference: word-by-word ascending copy with modulo-8192 addressing.
  task automatic model_copy(int k, int src, int dst, int n);
    for (int i = 0; i < n; i++) ref_mem[k][(dst + i) % 8192] = ref_mem[k][(src + i) % 8192];
  endtask

  task automatic compare_mem(int k, string tag);
    int bad   = 0;
    int first = -1;
    for (int a = 0; a < 8192; a++) begin
      if (mem_rd(k, 13'(a)) !== ref_mem[k][a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    check($sformatf("%s k%0d mem mismatches (first at %0d)", tag, k, first), bad, 0);
  endtask

  task automatic run_copy(int k, int src, int dst, int len, int restart_at, string tag);
    int lat      = (k == 0) ? 1 : 3;
    int exp_busy = len * (2 + lat);
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int cs_cnt   = 0;
    @(negedge clk);
    start_v[k] = 1'b1;
    src_v[k]   = 13'(src);
    dst_v[k]   = 13'(dst);
    len_v[k]   = 14'(len);
    @(negedge clk);
    start_v[k] = 1'b0;
    src_v[k]   = 13'($urandom);
    dst_v[k]   = 13'($urandom);
    len_v[k]   = 14'($urandom_range(1, 50));
    for (int c = 1; c <= exp_busy + 3; c++) begin
      start_v[k] = (c == restart_at);
      if (busy_v[k]) busy_cnt++;
      if (cs_v[k]) cs_cnt++;
      if (done_v[k]) begin
        done_cnt++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    start_v[k] = 1'b0;
    check($sformatf("%s k%0d busy cycles", tag, k), busy_cnt, exp_busy);
    check($sformatf("%s k%0d done pulses", tag, k), done_cnt, 1);
    check($sformatf("%s k%0d done cycle", tag, k), done_cyc, exp_busy + 1);
    check($sformatf("%s k%0d chipselect cycles", tag, k), cs_cnt, 2 * len);
    check($sformatf("%s k%0d words_done", tag, k), wd_v[k], len);
    model_copy(k, src, dst, len);
    compare_mem(k, tag);
  endtask

  initial begin
    int cnt_done;
    int cnt_cs;
    reset_n_v = '0;
    start_v   = '0;
    init_v    = '0;
    poke_v    = '0;
    poke_addr = '0;
    poke_data = '0;
    for (int k = 0; k < 2; k++) begin
      src_v[k]  = '0;
      dst_v[k]  = '0;
      len_v[k]  = '0;
      seed_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    reset_n_v = '1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_idle_outputs(k, "reset");

    init_mem(0, 32'h1234_5678);
    init_mem(1, 32'hCAFE_0001);

    // Basic four-word copy.
    for (int j = 0; j < 4; j++) poke(0, j, 32'h1111_1111 * (j + 1));
    run_copy(0, 0, 100, 4, 0, "basic");
    for (int j = 0; j < 4; j++)
      check($sformatf("basic mem[%0d]", 100 + j), mem_rd(0, 13'(100 + j)), 32'h1111_1111 * (j + 1));

    // Zero length: immediate done, no bus access.
    run_copy(0, 5, 600, 0, 0, "len0");

    // Wrap past the top of memory with overlapping, forward-propagating regions.
    poke(0, 8190, 32'hAAAA_0001);
    poke(0, 8191, 32'hBBBB_0002);
    poke(0, 0,    32'hCCCC_0003);
    run_copy(0, 8190, 8191, 3, 0, "wrap");
    check("wrap mem[8191]", mem_rd(0, 13'd8191), 32'hAAAA_0001);
    check("wrap mem[0]",    mem_rd(0, 13'd0),    32'hAAAA_0001);
    check("wrap mem[1]",    mem_rd(0, 13'd1),    32'hAAAA_0001);

    // Start pulsed mid-transfer with other parameters must be ignored.
    run_copy(0, 1000, 2000, 10, 5, "restart");

    // Reset after two of eight words: abandon, no done, first two words stay written.
    @(negedge clk);
    start_v[0] = 1'b1;
    src_v[0]   = 13'd200;
    dst_v[0]   = 13'd300;
    len_v[0]   = 14'd8;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (6) @(negedge clk);
    check("midreset words_done before reset", wd_v[0], 2);
    reset_n_v[0] = 1'b0;
    @(negedge clk);
    reset_n_v[0] = 1'b1;
    check_idle_outputs(0, "midreset");
    cnt_done = 0;
    cnt_cs   = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_v[0]) cnt_done++;
      if (cs_v[0]) cnt_cs++;
      @(negedge clk);
    end
    check("midreset done pulses", cnt_done, 0);
    check("midreset chipselect after reset", cnt_cs, 0);
    model_copy(0, 200, 300, 2);
    compare_mem(0, "midreset");

    // Read latency 3.
    run_copy(1, 40, 3000, 5, 0, "lat3");

    // Randomized transfers on both latencies, some with ignored restarts.
    for (int t = 0; t < 6; t++) begin
      for (int k = 0; k < 2; k++) begin
        int len = $urandom_range(0, 40);
        int rs  = (len > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(1, len * 2) : 0;
        run_copy(k, $urandom_range(0, 8191), $urandom_range(0, 8191), len, rs,
                 $sformatf("rand%0d", t));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
